truth_table_checker: RTL
========================

# truth_table_checker

Self-checking sequential response checker for small combinational gate blocks. It steps an N-input vector exhaustively from 0 to 2^N−1 and holds each vector for a programmable settle time. On the last cycle of each hold it samples the block's output, compares it against a parameterised expected truth table, and records the mismatch count and the first failing vector. It sits between the clocked bench/top level and a combinational DUT, replacing hand-written delay-based stimulus with a clocked, pass/fail result.

## Interface
- N_IN, 3, number of DUT inputs; the vector is presented as {MSB..LSB} = {A,B,C} for N_IN=3.
- EXPECTED, 8'b1100_1100, 2^N_IN-bit expected truth table; bit k is the expected F for vector k. The default encodes F = B.
- SETTLE_CYC, 4, cycles each vector is held before sampling; legal range 0..255.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  begin a run; accepted in IDLE or DONE.
- abort_i  input  1  terminate the current run and return to IDLE.
- f_i  input  1  DUT output under test.
- vec_o  output  N_IN  vector driven to DUT inputs.
- busy_o  output  1  run in progress.
- done_o  output  1  run complete; held until the next accepted start or an abort.
- pass_o  output  1  done_o and err_cnt_o == 0.
- err_cnt_o  output  N_IN+1  number of mismatching vectors in the run.
- first_err_valid_o  output  1  at least one mismatch recorded.
- first_err_idx_o  output  N_IN  index of the first mismatching vector.

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous) puts the block in IDLE. All outputs go to 0, and the internal settle counter goes to 0.
- IDLE: start_i=1 and abort_i=0 moves to RUN. The same edge clears vec_o, err_cnt_o, first_err_*, and the settle counter; busy_o goes to 1.
- RUN: vec_o holds vector k while the settle counter counts 0..SETTLE_CYC.
  - On the edge where the counter equals SETTLE_CYC, f_i is compared with EXPECTED[k].
  - Mismatch: err_cnt_o increments. If first_err_valid_o is 0, first_err_idx_o takes k and first_err_valid_o goes to 1.
  - If k < 2^N_IN−1: vec_o becomes k+1 and the counter returns to 0.
  - If k = 2^N_IN−1: go to DONE; busy_o=0, done_o=1. vec_o wraps to 0; no extra vector is applied.
- DONE: results are held stable. start_i=1 restarts exactly as from IDLE, including clearing the results. pass_o = done_o & (err_cnt_o == 0).
- abort_i=1 in RUN or DONE returns to IDLE on the next edge. It clears busy_o, done_o, and pass_o; err_cnt_o and first_err_* are left unchanged.
- abort_i has priority over start_i in every state.
- start_i is ignored while in RUN.
- Width rule: err_cnt_o has N_IN+1 bits, so the maximum of 2^N_IN mismatches fits without saturation logic.
- f_i is assumed to be driven combinationally from vec_o in the same clock domain. SETTLE_CYC ≥ 1 covers the DUT's propagation delay; no synchronizer is used.

## Timing
- Each vector occupies exactly SETTLE_CYC+1 cycles.
- A start accepted at edge t causes done_o to rise at edge t + 2^N_IN·(SETTLE_CYC+1). With the defaults this is t+40.
- f_i is sampled for vector k at edge t + (k+1)(SETTLE_CYC+1).
- vec_o changes only on a sampling edge or when a start is accepted.
- SETTLE_CYC=0: vectors advance every cycle, and f_i is compared in the same cycle that vec_o presents the vector.
- Reset asserted mid-run aborts immediately and asynchronously. After release the block waits in IDLE for start_i; there is no auto-restart.

## Structure
- Shared package ttc_pkg: the state enum ttc_state_e {IDLE, RUN, DONE} and the default constants TTC_N_IN=3, TTC_SETTLE=4, and TTC_EXP_F_EQ_B=8'hCC.
- One sub-module, ttc_settle_cnt: a loadable settle counter with clear and an "at terminal" flag. The FSM, vector register and scoreboard stay in the top module.

## Test plan
- Good DUT (f_i = vec_o[1]), defaults, start pulse → done_o at start+40 cycles, pass_o=1, err_cnt_o=0, first_err_valid_o=0.
- Faulty DUT (f_i stuck at 0), defaults → done_o=1, pass_o=0, err_cnt_o=4, first_err_idx_o=2.
- abort_i asserted in cycle 15 of a run → IDLE next edge, busy_o=0, done_o=0; a new start then completes in 40 cycles.
- rst_n pulsed low mid-run at vector 5 → all outputs 0 immediately; start_i held high through the reset release → run begins on the first edge with rst_n high, vec_o=0.
- SETTLE_CYC=0 with a good DUT → done_o at start+8, vec_o steps 0..7 on consecutive cycles, pass_o=1.
- start_i held high throughout a run → no restart mid-run; in DONE, start_i restarts on the next edge and clears err_cnt_o.

Source files
------------

// File: rtl/ttc_pkg.sv
// ============================================================================
// Module      : ttc_pkg
// Description : Shared state encoding and default constants for the truth
//               table checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ttc_state_e;

    localparam int         TTC_N_IN       = 3;
    localparam int         TTC_SETTLE     = 4;
    localparam logic [7:0] TTC_EXP_F_EQ_B = 8'hCC;

endpackage

`default_nettype wire

// File: rtl/ttc_settle_cnt.sv
// ============================================================================
// Module      : ttc_settle_cnt
// Description : Settle counter with clear, enable and a terminal-count flag;
//               wraps to zero on the enabled cycle that reaches the terminal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttc_settle_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_at_term
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_at_term;

    assign w_at_term = (r_cnt == i_term);
    assign o_at_term = w_at_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/truth_table_checker.sv
// ============================================================================
// Module      : truth_table_checker
// Description : Steps an N-input vector exhaustively, samples the DUT output at
//               the end of each settle window and scores it against EXPECTED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int                  N_IN       = TTC_N_IN,
    parameter logic [2**N_IN-1:0]  EXPECTED   = TTC_EXP_F_EQ_B,
    parameter int                  SETTLE_CYC = TTC_SETTLE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            f_i,
    output logic [N_IN-1:0] vec_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [N_IN:0]   err_cnt_o,
    output logic            first_err_valid_o,
    output logic [N_IN-1:0] first_err_idx_o
);

    localparam logic [7:0]      c_TERM     = 8'(SETTLE_CYC);
    localparam logic [N_IN-1:0] c_VEC_LAST = {N_IN{1'b1}};

    ttc_state_e      r_state;
    logic [N_IN-1:0] r_vec;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [N_IN:0]   r_err_cnt;
    logic            r_fev;
    logic [N_IN-1:0] r_fidx;

    logic w_start_acc;
    logic w_at_term;
    logic w_mismatch;

    assign w_start_acc = start_i & ~abort_i & (r_state != RUN);
    assign w_mismatch  = (f_i != EXPECTED[r_vec]);

    ttc_settle_cnt #(
        .WIDTH (8)
    ) u_settle_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_start_acc | abort_i),
        .i_en      (r_state == RUN),
        .i_term    (c_TERM),
        .o_at_term (w_at_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vec     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err_cnt <= '0;
            r_fev     <= 1'b0;
            r_fidx    <= '0;
        end else if (abort_i) begin
            // Results of the aborted run stay visible for inspection.
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_state   <= RUN;
                        r_vec     <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_err_cnt <= '0;
                        r_fev     <= 1'b0;
                        r_fidx    <= '0;
                    end
                end
                RUN: begin
                    if (w_at_term) begin
                        if (w_mismatch) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                            if (!r_fev) begin
                                r_fev  <= 1'b1;
                                r_fidx <= r_vec;
                            end
                        end
                        if (r_vec == c_VEC_LAST) begin
                            r_state <= DONE;
                            r_vec   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_cnt == '0) && !w_mismatch;
                        end else begin
                            r_vec <= r_vec + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vec_o             = r_vec;
    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign pass_o            = r_pass;
    assign err_cnt_o         = r_err_cnt;
    assign first_err_valid_o = r_fev;
    assign first_err_idx_o   = r_fidx;

endmodule

`default_nettype wire
